mem_wb_razor_stage: RTL and testbench

//   MEM/WB pipeline stage with Razor timing-error detection and one-cycle local recovery.
//   - Sits directly downstream of EX_MEM_reg and the data memory.
//   - Captures memory read data, ALU result, destination register and WB controls.
//   - Selects write-back data and drives the register file.
//   - Shadow-samples its inputs on the falling clock edge, flags late-arriving data,
//     and restores the correct value while stalling upstream for one cycle.

---
 rtl/mem_wb_razor_stage.sv | 129 ++++++++++++
 tb/tb_mem_wb_razor_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_razor_stage.sv
// MEM/WB stage: captures memory/ALU results, drives the register file, and uses a
// negedge shadow copy to catch late data, restore it, and stall upstream for one cycle.
// Ports: clk, reset (async, active-high); errorin (upstream error, forces a bubble);
//   MemData_in, res_in, regAddr_in, MemtoReg_in, RegWr_in, pcin (EX_MEM and memory inputs);
//   wbData_out, regAddr_out, RegWr_out (register-file write port);
//   errorout, stall_out, err_pc, err_count (Razor error status).
module mem_wb_razor_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             errorin,
  input  logic [DW-1:0]    MemData_in,
  input  logic [DW-1:0]    res_in,
  input  logic [DW-1:0]    regAddr_in,
  input  logic             MemtoReg_in,
  input  logic             RegWr_in,
  input  logic [DW-1:0]    pcin,
  output logic [DW-1:0]    wbData_out,
  output logic [DW-1:0]    regAddr_out,
  output logic             RegWr_out,
  output logic             errorout,
  output logic             stall_out,
  output logic [DW-1:0]    err_pc,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           state;
  logic [DW-1:0]    mem_q, res_q, addr_q, pc_q;
  logic             m2r_q, rw_q, rw_raw_q;
  logic             fresh_q;
  logic [DW-1:0]    sh_mem, sh_res, sh_addr;
  logic             sh_m2r, sh_rw;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    err_pc_q;
  logic             mismatch;

  // Compare against the ungated write enable so an upstream bubble
  // is not mistaken for late data.
  assign mismatch =
    {MemData_in, res_in, regAddr_in, MemtoReg_in, RegWr_in} !=
    {mem_q, res_q, addr_q, m2r_q, rw_raw_q};

  // Shadow capture and error detection on the falling edge.
  // fresh_q masks the compare when main was not loaded at the last
  // rising edge (after reset or after recovery), since upstream may
  // then present an instruction main never captured.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      sh_mem  <= '0;
      sh_res  <= '0;
      sh_addr <= '0;
      sh_m2r  <= 1'b0;
      sh_rw   <= 1'b0;
      err_q   <= 1'b0;
    end else if (state == RUN) begin
      sh_mem  <= MemData_in;
      sh_res  <= res_in;
      sh_addr <= regAddr_in;
      sh_m2r  <= MemtoReg_in;
      sh_rw   <= RegWr_in;
      err_q   <= fresh_q & mismatch;
    end else begin
      err_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      mem_q    <= '0;
      res_q    <= '0;
      addr_q   <= '0;
      m2r_q    <= 1'b0;
      rw_q     <= 1'b0;
      rw_raw_q <= 1'b0;
      pc_q     <= '0;
      fresh_q  <= 1'b0;
      err_pc_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (err_q) begin
            // Late data: restore the shadow copy; errorin is ignored.
            mem_q    <= sh_mem;
            res_q    <= sh_res;
            addr_q   <= sh_addr;
            m2r_q    <= sh_m2r;
            rw_q     <= sh_rw;
            rw_raw_q <= sh_rw;
            err_pc_q <= pc_q;
            if (cnt_q != '1)
              cnt_q <= cnt_q + CNT_W'(1);
            fresh_q  <= 1'b0;
            state    <= RECOVER;
          end else begin
            mem_q    <= MemData_in;
            res_q    <= res_in;
            addr_q   <= regAddr_in;
            m2r_q    <= MemtoReg_in;
            rw_q     <= RegWr_in & ~errorin;
            rw_raw_q <= RegWr_in;
            pc_q     <= pcin;
            fresh_q  <= 1'b1;
          end
        end
        RECOVER: begin
          fresh_q <= 1'b0;
          state   <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign errorout    = err_q & (state == RUN);
  assign stall_out   = (state == RECOVER);
  assign wbData_out  = m2r_q ? mem_q : res_q;
  assign regAddr_out = addr_q;
  assign RegWr_out   = rw_q & ~errorout;
  assign err_pc      = err_pc_q;
  assign err_count   = cnt_q;

endmodule

// File: tb/tb_mem_wb_razor_stage.sv
// Directed bench for mem_wb_razor_stage: reset, capture, late data
// recovery, bubbles, reset during recovery and counter saturation.
module tb_mem_wb_razor_stage;

  localparam int DW = 32;

  logic          clk, reset, errorin;
  logic [DW-1:0] MemData_in, res_in, regAddr_in, pcin;
  logic          MemtoReg_in, RegWr_in;

  logic [DW-1:0] wbData_out, regAddr_out, err_pc;
  logic          RegWr_out, errorout, stall_out;
  logic [7:0]    err_count;

  logic [DW-1:0] s_wb, s_addr, s_pc;
  logic          s_rw, s_err, s_stall;
  logic [1:0]    s_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  mem_wb_razor_stage #(.DW(DW), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .errorin(errorin),
    .MemData_in(MemData_in), .res_in(res_in),
    .regAddr_in(regAddr_in), .MemtoReg_in(MemtoReg_in),
    .RegWr_in(RegWr_in), .pcin(pcin),
    .wbData_out(wbData_out), .regAddr_out(regAddr_out),
    .RegWr_out(RegWr_out), .errorout(errorout),
    .stall_out(stall_out), .err_pc(err_pc),
    .err_count(err_count)
  );

  mem_wb_razor_stage #(.DW(DW), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .errorin(errorin),
    .MemData_in(MemData_in), .res_in(res_in),
    .regAddr_in(regAddr_in), .MemtoReg_in(MemtoReg_in),
    .RegWr_in(RegWr_in), .pcin(pcin),
    .wbData_out(s_wb), .regAddr_out(s_addr),
    .RegWr_out(s_rw), .errorout(s_err),
    .stall_out(s_stall), .err_pc(s_pc),
    .err_count(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic rise();
    @(posedge clk); #1;
  endtask

  task automatic fall();
    @(negedge clk); #1;
  endtask

  task automatic set_in(input logic [DW-1:0] mem, input logic [DW-1:0] res,
                        input logic [DW-1:0] addr, input logic m2r,
                        input logic rw, input logic [DW-1:0] pc);
    MemData_in  = mem;
    res_in      = res;
    regAddr_in  = addr;
    MemtoReg_in = m2r;
    RegWr_in    = rw;
    pcin        = pc;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({wbData_out, regAddr_out, err_pc} !== '0) begin
      $display("FAIL reset_data got %h/%h/%h exp 0", wbData_out, regAddr_out, err_pc);
      n_bad++;
    end
    n_cmp++;
    if ({RegWr_out, errorout, stall_out} !== 3'b000) begin
      $display("FAIL reset_flags got %b%b%b exp 000", RegWr_out, errorout, stall_out);
      n_bad++;
    end
    n_cmp++;
    if (err_count !== 8'd0 || s_cnt !== 2'd0) begin
      $display("FAIL reset_cnt got %0d/%0d exp 0", err_count, s_cnt);
      n_bad++;
    end
    fall();
    reset = 1'b0;
  endtask

  task automatic test_capture();
    set_in(32'hAAAA, 32'h10, 32'd5, 1'b0, 1'b1, 32'h100);
    rise();
    n_cmp++;
    if (wbData_out !== 32'h10 || regAddr_out !== 32'd5) begin
      $display("FAIL cap_res got %h/%h exp 10/5", wbData_out, regAddr_out);
      n_bad++;
    end
    n_cmp++;
    if (RegWr_out !== 1'b1 || stall_out !== 1'b0) begin
      $display("FAIL cap_rw got %b/%b exp 1/0", RegWr_out, stall_out);
      n_bad++;
    end
    fall();
    n_cmp++;
    if (errorout !== 1'b0 || err_count !== 8'd0) begin
      $display("FAIL cap_err got %b/%0d exp 0/0", errorout, err_count);
      n_bad++;
    end
    set_in(32'h55, 32'h11, 32'd6, 1'b1, 1'b1, 32'h104);
    rise();
    n_cmp++;
    if (wbData_out !== 32'h55) begin
      $display("FAIL cap_mem got %h exp 55", wbData_out);
      n_bad++;
    end
    fall();
    n_cmp++;
    if (errorout !== 1'b0) begin
      $display("FAIL cap_mem_err got %b exp 0", errorout);
      n_bad++;
    end
  endtask

  task automatic test_late();
    set_in(32'h0, 32'h10, 32'd7, 1'b0, 1'b1, 32'h200);
    rise();
    res_in = 32'h20;
    fall();
    n_cmp++;
    if (errorout !== 1'b1 || RegWr_out !== 1'b0) begin
      $display("FAIL late_flag got err=%b rw=%b exp 1/0", errorout, RegWr_out);
      n_bad++;
    end
    rise();
    exp_cnt = 1;
    n_cmp++;
    if (wbData_out !== 32'h20 || stall_out !== 1'b1) begin
      $display("FAIL late_fix got %h/%b exp 20/1", wbData_out, stall_out);
      n_bad++;
    end
    n_cmp++;
    if (err_count !== 8'd1 || err_pc !== 32'h200) begin
      $display("FAIL late_cnt got %0d/%h exp 1/200", err_count, err_pc);
      n_bad++;
    end
    n_cmp++;
    if (RegWr_out !== 1'b1 || errorout !== 1'b0) begin
      $display("FAIL late_rw got %b/%b exp 1/0", RegWr_out, errorout);
      n_bad++;
    end
    fall();
    n_cmp++;
    if (errorout !== 1'b0) begin
      $display("FAIL late_rec_err got %b exp 0", errorout);
      n_bad++;
    end
    rise();
    n_cmp++;
    if (stall_out !== 1'b0 || wbData_out !== 32'h20) begin
      $display("FAIL late_ret got %b/%h exp 0/20", stall_out, wbData_out);
      n_bad++;
    end
    fall();
  endtask

  task automatic test_bubble();
    errorin = 1'b1;
    set_in(32'h0, 32'h30, 32'd8, 1'b0, 1'b1, 32'h300);
    rise();
    n_cmp++;
    if (RegWr_out !== 1'b0 || wbData_out !== 32'h30) begin
      $display("FAIL bub_rw got %b/%h exp 0/30", RegWr_out, wbData_out);
      n_bad++;
    end
    fall();
    n_cmp++;
    if (errorout !== 1'b0 || err_count !== 8'(exp_cnt)) begin
      $display("FAIL bub_err got %b/%0d exp 0/%0d", errorout, err_count, exp_cnt);
      n_bad++;
    end
    errorin = 1'b0;
  endtask

  task automatic test_late_errorin();
    set_in(32'h0, 32'h40, 32'd9, 1'b0, 1'b1, 32'h400);
    rise();
    res_in  = 32'h41;
    errorin = 1'b1;
    fall();
    n_cmp++;
    if (errorout !== 1'b1) begin
      $display("FAIL le_flag got %b exp 1", errorout);
      n_bad++;
    end
    rise();
    exp_cnt = 2;
    n_cmp++;
    if (stall_out !== 1'b1 || err_count !== 8'd2 || err_pc !== 32'h400) begin
      $display("FAIL le_rec got %b/%0d/%h exp 1/2/400", stall_out, err_count, err_pc);
      n_bad++;
    end
    n_cmp++;
    if (RegWr_out !== 1'b1 || wbData_out !== 32'h41) begin
      $display("FAIL le_rw got %b/%h exp 1/41", RegWr_out, wbData_out);
      n_bad++;
    end
    rise();
    n_cmp++;
    if (stall_out !== 1'b0 || RegWr_out !== 1'b1) begin
      $display("FAIL le_ret got %b/%b exp 0/1", stall_out, RegWr_out);
      n_bad++;
    end
    rise();
    n_cmp++;
    if (RegWr_out !== 1'b0 || err_count !== 8'd2) begin
      $display("FAIL le_bub got %b/%0d exp 0/2", RegWr_out, err_count);
      n_bad++;
    end
    fall();
    errorin = 1'b0;
  endtask

  task automatic test_reset_recover();
    set_in(32'h0, 32'h50, 32'd10, 1'b0, 1'b1, 32'h500);
    rise();
    res_in = 32'h51;
    fall();
    rise();
    exp_cnt = 3;
    n_cmp++;
    if (stall_out !== 1'b1 || s_cnt !== 2'd3) begin
      $display("FAIL rr_pre got %b/%0d exp 1/3", stall_out, s_cnt);
      n_bad++;
    end
    #2 reset = 1'b1;
    #1;
    exp_cnt = 0;
    n_cmp++;
    if (stall_out !== 1'b0 || RegWr_out !== 1'b0 || errorout !== 1'b0) begin
      $display("FAIL rr_flags got %b%b%b exp 000", stall_out, RegWr_out, errorout);
      n_bad++;
    end
    n_cmp++;
    if (err_count !== 8'd0 || err_pc !== '0 || wbData_out !== '0) begin
      $display("FAIL rr_state got %0d/%h/%h exp 0", err_count, err_pc, wbData_out);
      n_bad++;
    end
    fall();
    reset = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      set_in(32'h0, 32'(i), 32'd11, 1'b0, 1'b1, 32'h600 + 32'(4 * i));
      rise();
      res_in = 32'h80 + 32'(i);
      fall();
      n_cmp++;
      if (s_err !== 1'b1) begin
        $display("FAIL sat_flag%0d got %b exp 1", i, s_err);
        n_bad++;
      end
      rise();
      exp_cnt++;
      n_cmp++;
      if (err_count !== 8'(exp_cnt) ||
          s_cnt !== 2'((exp_cnt > 3) ? 3 : exp_cnt)) begin
        $display("FAIL sat_cnt%0d got %0d/%0d exp %0d", i, err_count, s_cnt, exp_cnt);
        n_bad++;
      end
      rise();
      fall();
    end
    n_cmp++;
    if (s_cnt !== 2'd3 || s_pc !== 32'h610) begin
      $display("FAIL sat_end got %0d/%h exp 3/610", s_cnt, s_pc);
      n_bad++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    errorin = 1'b0;
    set_in('0, '0, '0, 1'b0, 1'b0, '0);
    test_reset();
    test_capture();
    test_late();
    test_bubble();
    test_late_errorin();
    test_reset_recover();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
